regfile_wb_arbiter: RTL and testbench

Shares the single write port of the 32×32 register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/memory writeback. It grants at most one write per cycle using round-robin arbitration and stages the granted write in an output register that drives the file's write port (A3/WD/We). It also forwards the staged, not-yet-committed write to two read-address queries, so the datapath never reads stale data during the one-cycle staging window.

---
 rtl/rf_pkg.sv | 15 +
 rtl/wb_rr_arb2.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 71 +++++++
 tb/tb_regfile_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    // Round-robin pointer: names the requester that wins the next tie.
    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_t;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational from the valids and
// the priority pointer; the pointer moves past the winner on each handshake.
//
//   state | meaning
//   ------+----------------------------------------------
//   PRIO0 | requester 0 wins when both are valid
//   PRIO1 | requester 1 wins when both are valid
module wb_rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    prio_t prio_q;
    prio_t prio_d;

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PRIO0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Grant selection and pointer update.
    always_comb begin
        grant  = 2'b00;
        prio_d = prio_q;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (prio_q == PRIO0) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance) begin
            if (grant[0]) begin
                prio_d = PRIO1;
            end else if (grant[1]) begin
                prio_d = PRIO0;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback. The
// granted write is staged for one cycle in rf_a3/rf_wd/rf_we, and that staged
// write is forwarded to the two read ports until the file commits it.
module regfile_wb_arbiter
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    output logic            rf_we,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data
);

    logic [1:0]      grant;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    wb_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (xfer),
        .grant   (grant)
    );

    // A grant is only ever issued to a valid requester, so any grant is a transfer.
    assign xfer       = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    // Staging register driving the file write port; x0 writes are accepted but never enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else if (xfer) begin
            rf_we <= (sel_addr != REG_ZERO);
            rf_a3 <= sel_addr;
            rf_wd <= sel_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Forward the staged write to reads that would otherwise see the old value.
    always_comb begin
        fwd1_hit  = rf_we && (rf_a3 == ra1) && (ra1 != REG_ZERO);
        fwd2_hit  = rf_we && (rf_a3 == ra2) && (ra2 != REG_ZERO);
        fwd1_data = rf_wd;
        fwd2_data = rf_wd;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a simple register file model
// attached to the write port.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf_mem [32];

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_a3      (rf_a3),
        .rf_wd      (rf_wd),
        .rf_we      (rf_we),
        .ra1        (ra1),
        .ra2        (ra2),
        .fwd1_hit   (fwd1_hit),
        .fwd2_hit   (fwd2_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: commits the staged write on the rising edge.
    always @(posedge clk) begin
        if (rf_we && rf_a3 != 5'd0) rf_mem[rf_a3] <= rf_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] n0;
        logic [31:0] n1;
        logic        g;

        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0;
        rst        = 1'b1;
        req0_valid = 1'b0;
        req0_addr  = 5'd0;
        req0_data  = 32'h0;
        req1_valid = 1'b0;
        req1_addr  = 5'd0;
        req1_data  = 32'h0;
        ra1        = 5'd0;
        ra2        = 5'd0;
        #1;
        chk("reset_we", {31'd0, rf_we}, 32'd0);
        chk("reset_a3", {27'd0, rf_a3}, 32'd0);
        chk("reset_wd", rf_wd, 32'd0);
        chk("reset_ready0", {31'd0, req0_ready}, 32'd0);
        chk("reset_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single write to x5
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("single_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("single_we", {31'd0, rf_we}, 32'd1);
        chk("single_a3", {27'd0, rf_a3}, 32'd5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        step();
        chk("single_read_x5", rf_mem[5], 32'hDEADBEEF);
        chk("single_we_drop", {31'd0, rf_we}, 32'd0);

        // Requester 1 alone moves the pointer back to requester 0
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
        #1;
        chk("r1_alone_ready1", {31'd0, req1_ready}, 32'd1);
        chk("r1_alone_ready0", {31'd0, req0_ready}, 32'd0);
        step();
        req1_valid = 1'b0;
        chk("r1_alone_a3", {27'd0, rf_a3}, 32'd2);
        step();

        // Contention, pointer at requester 0
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        #1;
        chk("cont_ready0_first", {31'd0, req0_ready}, 32'd1);
        chk("cont_ready1_first", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        chk("cont_a3_first", {27'd0, rf_a3}, 32'd3);
        chk("cont_wd_first", rf_wd, 32'h11);
        chk("cont_ready1_second", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        chk("cont_a3_second", {27'd0, rf_a3}, 32'd4);
        chk("cont_wd_second", rf_wd, 32'h22);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("cont_prio_end", {30'd0, req1_ready, req0_ready}, 32'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("cont_read_x3", rf_mem[3], 32'h11);
        chk("cont_read_x4", rf_mem[4], 32'h22);

        // Sustained contention: grants alternate 0,1,0,1,0,1
        n0 = 32'hA00; n1 = 32'hB00;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = n0;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = n1;
        for (int i = 0; i < 6; i++) begin
            g = (i % 2 == 1);
            #1;
            chk("sus_grant", {30'd0, req1_ready, req0_ready}, g ? 32'b10 : 32'b01);
            step();
            chk("sus_a3", {27'd0, rf_a3}, g ? 32'd11 : 32'd10);
            chk("sus_wd", rf_wd, g ? n1 : n0);
            if (g) begin n1 = n1 + 1; req1_data = n1; end
            else   begin n0 = n0 + 1; req0_data = n0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("sus_read_x10", rf_mem[10], 32'hA02);
        chk("sus_read_x11", rf_mem[11], 32'hB02);

        // Same address from both requesters
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hAAAA;
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hBBBB;
        step();
        req0_valid = 1'b0;
        chk("same_wd_first", rf_wd, 32'hAAAA);
        step();
        req1_valid = 1'b0;
        chk("same_wd_second", rf_wd, 32'hBBBB);
        step();
        chk("same_read_x7", rf_mem[7], 32'hBBBB);

        // x0 write is accepted but never enabled
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234;
        #1;
        chk("x0_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        ra1 = 5'd0;
        #1;
        chk("x0_we", {31'd0, rf_we}, 32'd0);
        chk("x0_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_addr = 5'd1; req1_data = 32'h0;
        #1;
        chk("x0_prio_adv", {30'd0, req1_ready, req0_ready}, 32'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Forwarding of the staged write, then reset in the staging cycle
        req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h55;
        step();
        req0_valid = 1'b0;
        ra1 = 5'd9; ra2 = 5'd8;
        #1;
        chk("fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("fwd1_data", fwd1_data, 32'h55);
        chk("fwd2_miss", {31'd0, fwd2_hit}, 32'd0);
        ra2 = 5'd9;
        #1;
        chk("fwd2_hit", {31'd0, fwd2_hit}, 32'd1);
        chk("fwd2_data", fwd2_data, 32'h55);
        rst = 1'b1;
        #1;
        chk("rst_we_drop", {31'd0, rf_we}, 32'd0);
        chk("rst_fwd1_drop", {31'd0, fwd1_hit}, 32'd0);
        step();
        chk("rst_read_x9", rf_mem[9], 32'h0);
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_prio0", {30'd0, req1_ready, req0_ready}, 32'b01);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
